// File: rtl/fp_to_int.sv
// IEEE-754 single to signed 32-bit integer converter, one shift bit per cycle; optional
// round-half-even under `FP_ROUND_NEAREST_EN (default build truncates toward zero).
// Latency N+2 on the shift path, 1 for specials; ready_o only in IDLE, valid_i ignored otherwise.
module fp_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] data_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        overflow_o,
    output logic        invalid_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_mag;
    logic [4:0]  r_cnt;
    logic        r_left;
    logic        r_sign;
    logic [31:0] r_data;
    logic        r_ovf;
    logic        r_inv;
`ifdef FP_ROUND_NEAREST_EN
    logic        r_guard;
    logic        r_sticky;
`endif

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic        w_left;
    logic [4:0]  w_n;
    logic        w_special;
    logic [31:0] w_spec_data;
    logic        w_spec_ovf;
    logic        w_spec_inv;
    logic [31:0] w_mag_rnd;
    logic [31:0] w_result;

    assign w_sign = data_i[31];
    assign w_exp  = data_i[30:23];
    assign w_man  = data_i[22:0];

    // Shift path only sees exponents 127..157, so |exp-150| fits in 5 bits and mod-32 math is exact.
    assign w_left = (w_exp >= 8'd150);
    assign w_n    = w_left ? (w_exp[4:0] - 5'd22) : (5'd22 - w_exp[4:0]);

    always_comb begin
        w_special   = 1'b1;
        w_spec_data = 32'h0000_0000;
        w_spec_ovf  = 1'b0;
        w_spec_inv  = 1'b0;
        if (w_exp == 8'hFF) begin
            w_spec_inv  = 1'b1;
            w_spec_data = (w_sign && (w_man == 23'd0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (w_exp >= 8'd158) begin
            if (data_i == 32'hCF00_0000) begin
                w_spec_data = 32'h8000_0000;
            end else begin
                w_spec_ovf  = 1'b1;
                w_spec_data = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else if (w_exp < 8'd127) begin
`ifdef FP_ROUND_NEAREST_EN
            // 0.5 < |x| < 1 rounds to 1; exactly 0.5 ties to even (0)
            if ((w_exp == 8'd126) && (w_man != 23'd0))
                w_spec_data = w_sign ? 32'hFFFF_FFFF : 32'h0000_0001;
`endif
        end else begin
            w_special = 1'b0;
        end
    end

`ifdef FP_ROUND_NEAREST_EN
    assign w_mag_rnd = r_mag + {31'd0, r_guard & (r_sticky | r_mag[0])};
`else
    assign w_mag_rnd = r_mag;
`endif
    assign w_result = r_sign ? (32'd0 - w_mag_rnd) : w_mag_rnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mag    <= 32'd0;
            r_cnt    <= 5'd0;
            r_left   <= 1'b0;
            r_sign   <= 1'b0;
            r_data   <= 32'd0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
`ifdef FP_ROUND_NEAREST_EN
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_sign <= w_sign;
                        if (w_special) begin
                            r_data  <= w_spec_data;
                            r_ovf   <= w_spec_ovf;
                            r_inv   <= w_spec_inv;
                            r_state <= OUT;
                        end else begin
                            r_mag    <= {8'd0, 1'b1, w_man};
                            r_cnt    <= w_n;
                            r_left   <= w_left;
`ifdef FP_ROUND_NEAREST_EN
                            r_guard  <= 1'b0;
                            r_sticky <= 1'b0;
`endif
                            r_state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                        if (r_left) begin
                            r_mag <= {r_mag[30:0], 1'b0};
                        end else begin
                            r_mag <= {1'b0, r_mag[31:1]};
`ifdef FP_ROUND_NEAREST_EN
                            r_guard  <= r_mag[0];
                            r_sticky <= r_sticky | r_guard;
`endif
                        end
                    end else begin
                        r_data  <= w_result;
                        r_ovf   <= 1'b0;
                        r_inv   <= 1'b0;
                        r_state <= OUT;
                    end
                end
                OUT:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o    = (r_state == IDLE);
    assign valid_o    = (r_state == OUT);
    assign data_o     = r_data;
    assign overflow_o = r_ovf;
    assign invalid_o  = r_inv;

endmodule
